// File: rtl/elevator_request_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_request_ctrl
//   Request side of the elevator cab FSM link for a 4-floor car (floors 0..3).
//   Latches cab and hall calls, chooses the next target floor and offers it to
//   the cab FSM with a small offer/ack handshake, raises door-open and
//   leave-stop requests, and runs the door/travel seconds timer.
//
//   Handshake on next_stage: next_stage[2] is the "offer valid" flag. An offer
//   is held stable until the FSM acknowledges it with a rising FR_Delay. After
//   that next_stage is 0 until FR_Delay has been seen low, so two acks can
//   never be taken for one offer.
//
//   Build option: define CAB_PRIORITY_EN to make target selection consider cab
//   calls alone first, falling back to hall calls only when no cab call gives
//   a candidate. Without it, cab and hall calls are merged per floor.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   cab_btn[3:0]  in   cab floor buttons (level)
//   hall_up[3:0]  in   hall up calls, bit 3 ignored
//   hall_dn[3:0]  in   hall down calls, bit 0 ignored
//   FR_Delay      in   FSM ack that next_stage was taken
//   Delay         in   FSM arrival strobe
//   Actual_Stage  in   current floor from FSM
//   UD_Answer     in   FSM travel direction, 1 = up
//   STOP          in   FSM parked in stop state
//   reset_clock   in   FSM timer restart request
//   next_stage    out  {1'b1, floor} offered target, 3'b000 = none
//   OC_Request    out  open doors at current floor
//   UD_Request    out  resume direction, 1 = up
//   NO_STOP       out  leave stop state, work pending
//   actual_clock  out  seconds since last reset_clock, saturating
//   pending       out  per-floor OR of all latched calls
// ---------------------------------------------------------------------------
module elevator_request_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CLK_SAT  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cab_btn,
    input  logic [3:0] hall_up,
    input  logic [3:0] hall_dn,
    input  logic       FR_Delay,
    input  logic       Delay,
    input  logic [1:0] Actual_Stage,
    input  logic       UD_Answer,
    input  logic       STOP,
    input  logic       reset_clock,
    output logic [2:0] next_stage,
    output logic       OC_Request,
    output logic       UD_Request,
    output logic       NO_STOP,
    output logic [3:0] actual_clock,
    output logic [3:0] pending
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]     SAT       = 4'(CLK_SAT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_ACKED = 2'd2;

    logic [3:0]    cab_q, hup_q, hdn_q;
    logic [3:0]    cab_n, hup_n, hdn_n;
    logic [3:0]    clr_cab, clr_up, clr_dn;
    logic          fr_q, rc_q;
    logic          fr_rise, rc_rise, serve;
    logic          here_n;
    logic [3:0]    above_mask, below_mask;
    logic          any_above, any_below;
    logic [2:0]    cand;
    logic [1:0]    state_q;
    logic [PW-1:0] presc_q;

    // Select, OC and NO_STOP are re-evaluated from the live FSM inputs every
    // cycle, so the arrival strobe carries no extra information here.
    logic unused_delay;
    assign unused_delay = Delay;

    // Returns {found, floor}: in the travel direction the nearest pending
    // floor beyond the current one, otherwise the nearest one behind.
    function automatic logic [2:0] pick(input logic [3:0] v,
                                        input logic [1:0] cur,
                                        input logic       up);
        logic       found_a, found_b;
        logic [1:0] lo_a, hi_b;
        found_a = 1'b0;
        found_b = 1'b0;
        lo_a    = 2'd0;
        hi_b    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i] && (i > int'(cur))) begin
                found_a = 1'b1;
                lo_a    = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i] && (i < int'(cur))) begin
                found_b = 1'b1;
                hi_b    = 2'(i);
            end
        end
        if (up)
            return found_a ? {1'b1, lo_a} : (found_b ? {1'b1, hi_b} : 3'b000);
        else
            return found_b ? {1'b1, hi_b} : (found_a ? {1'b1, lo_a} : 3'b000);
    endfunction

    assign pending = cab_q | hup_q | hdn_q;
    assign fr_rise = FR_Delay & ~fr_q;
    assign rc_rise = reset_clock & ~rc_q;
    // A timer restart while the doors were requested open means the floor
    // has been served.
    assign serve   = rc_rise & OC_Request;

    always_comb begin
        clr_cab = 4'b0000;
        clr_up  = 4'b0000;
        clr_dn  = 4'b0000;
        if (serve) begin
            clr_cab[Actual_Stage] = 1'b1;
            if (UD_Answer) clr_up[Actual_Stage] = 1'b1;
            else           clr_dn[Actual_Stage] = 1'b1;
        end
    end

    // A button held during its own service keeps the call alive.
    assign cab_n = (cab_q & ~clr_cab) | cab_btn;
    assign hup_n = (hup_q & ~clr_up)  | (hall_up & 4'b0111);
    assign hdn_n = (hdn_q & ~clr_dn)  | (hall_dn & 4'b1110);

    // Door request looks at next-cycle call state so it drops together with
    // the clear of the served call.
    assign here_n = cab_n[Actual_Stage] |
                    (UD_Answer ? hup_n[Actual_Stage] : hdn_n[Actual_Stage]);

    assign above_mask = 4'b1110 << Actual_Stage;
    assign below_mask = ~(above_mask | (4'b0001 << Actual_Stage));
    assign any_above  = |(pending & above_mask);
    assign any_below  = |(pending & below_mask);

`ifdef CAB_PRIORITY_EN
    logic [2:0] cab_pick;
    always_comb begin
        cab_pick = pick(cab_q, Actual_Stage, UD_Answer);
        cand     = cab_pick[2] ? cab_pick : pick(pending, Actual_Stage, UD_Answer);
    end
`else
    always_comb begin
        cand = pick(pending, Actual_Stage, UD_Answer);
    end
`endif

    // Call registers, input edge registers and FSM-facing request outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cab_q      <= 4'b0000;
            hup_q      <= 4'b0000;
            hdn_q      <= 4'b0000;
            fr_q       <= 1'b0;
            rc_q       <= 1'b0;
            OC_Request <= 1'b0;
            UD_Request <= 1'b1;
            NO_STOP    <= 1'b0;
        end else begin
            cab_q      <= cab_n;
            hup_q      <= hup_n;
            hdn_q      <= hdn_n;
            fr_q       <= FR_Delay;
            rc_q       <= reset_clock;
            OC_Request <= ~STOP & here_n;
            NO_STOP    <= STOP & (|pending);
            if (STOP) begin
                if (any_above)      UD_Request <= 1'b1;
                else if (any_below) UD_Request <= 1'b0;
            end
        end
    end

    // Offer FSM: hold an offer until acked, then wait for the ack to go low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            next_stage <= 3'b000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cand[2]) begin
                        state_q    <= ST_OFFER;
                        next_stage <= cand;
                    end
                end
                ST_OFFER: begin
                    if (fr_rise) begin
                        state_q    <= ST_ACKED;
                        next_stage <= 3'b000;
                    end
                end
                ST_ACKED: begin
                    if (!FR_Delay) state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    next_stage <= 3'b000;
                end
            endcase
        end
    end

    // Seconds timer; a restart request beats a coincident prescaler wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            actual_clock <= 4'd0;
        end else if (rc_rise) begin
            presc_q      <= '0;
            actual_clock <= 4'd0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            if (actual_clock < SAT) actual_clock <= actual_clock + 4'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_elevator_request_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_request_ctrl
//   Directed bench for elevator_request_ctrl with TICK_DIV=4. Stimulus pushes
//   the expected observation (masked field vector) into a queue right after a
//   rising edge; a monitor pops and compares on the following falling edge.
//   Observation vector: {next_stage, OC_Request, UD_Request, NO_STOP,
//   actual_clock, pending}.
// ---------------------------------------------------------------------------
module tb_elevator_request_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] cab_btn, hall_up, hall_dn;
    logic       FR_Delay, Delay, UD_Answer, STOP, reset_clock;
    logic [1:0] Actual_Stage;
    logic [2:0] next_stage;
    logic       OC_Request, UD_Request, NO_STOP;
    logic [3:0] actual_clock, pending;

    elevator_request_ctrl #(.TICK_DIV(4), .CLK_SAT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .cab_btn      (cab_btn),
        .hall_up      (hall_up),
        .hall_dn      (hall_dn),
        .FR_Delay     (FR_Delay),
        .Delay        (Delay),
        .Actual_Stage (Actual_Stage),
        .UD_Answer    (UD_Answer),
        .STOP         (STOP),
        .reset_clock  (reset_clock),
        .next_stage   (next_stage),
        .OC_Request   (OC_Request),
        .UD_Request   (UD_Request),
        .NO_STOP      (NO_STOP),
        .actual_clock (actual_clock),
        .pending      (pending)
    );

    localparam logic [13:0] M_NS   = 14'h3800;
    localparam logic [13:0] M_OC   = 14'h0400;
    localparam logic [13:0] M_UD   = 14'h0200;
    localparam logic [13:0] M_NOS  = 14'h0100;
    localparam logic [13:0] M_CLK  = 14'h00F0;
    localparam logic [13:0] M_PEND = 14'h000F;
    localparam logic [13:0] M_ALL  = 14'h3FFF;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [13:0] exp_q[$];
    logic [13:0] mask_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [13:0] obs;

    assign obs = {next_stage, OC_Request, UD_Request, NO_STOP, actual_clock, pending};

    function automatic logic [13:0] mk(input logic [2:0] ns, input logic oc,
                                       input logic ud, input logic nos,
                                       input logic [3:0] ck, input logic [3:0] pd);
        return {ns, oc, ud, nos, ck, pd};
    endfunction

    task automatic expect_obs(input string nm, input logic [13:0] m, input logic [13:0] v);
        name_q.push_back(nm);
        mask_q.push_back(m);
        exp_q.push_back(v);
    endtask

    // monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [13:0] e, m;
            string       nm;
            e  = exp_q.pop_front();
            m  = mask_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (((obs ^ e) & m) !== 14'h0) begin
                bad++;
                $display("FAIL %s: got %h expected %h (mask %h)", nm, obs & m, e & m, m);
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_offer();
        FR_Delay = 1'b1;
        tick(1);
        FR_Delay = 1'b0;
        tick(2);
    endtask

    logic [2:0] prio_exp;

    initial begin
        int e;
        int waitc;
        reset = 1'b0; cab_btn = 4'b0; hall_up = 4'b0; hall_dn = 4'b0;
        FR_Delay = 1'b0; Delay = 1'b0; Actual_Stage = 2'd0; UD_Answer = 1'b1;
        STOP = 1'b1; reset_clock = 1'b0;
        tick(1);
        expect_obs("reset_state", M_ALL, mk(3'b000, 0, 1, 0, 4'd0, 4'b0000));
        tick(2);
        reset = 1'b1;

        // cab call at floor 2 while stopped at floor 0
        cab_btn = 4'b0100;
        tick(1);
        cab_btn = 4'b0000;
        tick(1);
        expect_obs("t2_stop_req", M_PEND | M_NOS | M_UD, mk(3'b000, 0, 1, 1, 4'd0, 4'b0100));
        STOP = 1'b0;
        tick(1);
        expect_obs("t2_offer", M_NS | M_NOS | M_OC, mk(3'b110, 0, 0, 0, 4'd0, 4'b0000));

        // ack handshake
        FR_Delay = 1'b1;
        tick(1);
        expect_obs("t3_ack", M_NS, mk(3'b000, 0, 0, 0, 4'd0, 4'b0000));
        tick(3);
        expect_obs("t3_hold", M_NS, mk(3'b000, 0, 0, 0, 4'd0, 4'b0000));
        FR_Delay = 1'b0;
        tick(1);
        expect_obs("t3_gap", M_NS, mk(3'b000, 0, 0, 0, 4'd0, 4'b0000));
        tick(1);
        expect_obs("t3_reoffer", M_NS, mk(3'b110, 0, 0, 0, 4'd0, 4'b0000));

        // door request and service clear at floor 1
        Actual_Stage = 2'd1; UD_Answer = 1'b1; hall_up = 4'b0010;
        tick(1);
        hall_up = 4'b0000;
        expect_obs("t4_oc", M_OC | M_PEND, mk(3'b000, 1, 0, 0, 4'd0, 4'b0110));
        reset_clock = 1'b1;
        tick(1);
        reset_clock = 1'b0;
        expect_obs("t4_clear", M_OC | M_PEND | M_CLK, mk(3'b000, 0, 0, 0, 4'd0, 4'b0100));
        hall_dn = 4'b0010;
        tick(1);
        hall_dn = 4'b0000;
        expect_obs("t4_wrong_dir", M_OC | M_PEND, mk(3'b000, 0, 0, 0, 4'd0, 4'b0110));
        UD_Answer = 1'b0;
        tick(1);
        expect_obs("t4_dn_oc", M_OC, mk(3'b000, 1, 0, 0, 4'd0, 4'b0000));
        reset_clock = 1'b1;
        tick(1);
        reset_clock = 1'b0;
        expect_obs("t4_dn_clear", M_OC | M_PEND, mk(3'b000, 0, 0, 0, 4'd0, 4'b0100));
        hall_up = 4'b1000; hall_dn = 4'b0001;
        tick(1);
        hall_up = 4'b0000; hall_dn = 4'b0000;
        expect_obs("ignored_bits", M_PEND, mk(3'b000, 0, 0, 0, 4'd0, 4'b0100));

        // timer free run and saturation
        reset_clock = 1'b1;
        tick(1);
        reset_clock = 1'b0;
        expect_obs("t5_start", M_CLK, mk(3'b000, 0, 0, 0, 4'd0, 4'b0000));
        for (int k = 1; k <= 80; k++) begin
            tick(1);
            e = (k / 4 > 15) ? 15 : k / 4;
            expect_obs("t5_run", M_CLK, mk(3'b000, 0, 0, 0, 4'(e), 4'b0000));
        end
        reset_clock = 1'b1;
        tick(1);
        reset_clock = 1'b0;
        tick(7);
        expect_obs("t5_pre_wrap", M_CLK, mk(3'b000, 0, 0, 0, 4'd1, 4'b0000));
        reset_clock = 1'b1;
        tick(1);
        reset_clock = 1'b0;
        expect_obs("t5_coincide", M_CLK, mk(3'b000, 0, 0, 0, 4'd0, 4'b0000));
        tick(3);
        expect_obs("t5_after_3", M_CLK, mk(3'b000, 0, 0, 0, 4'd0, 4'b0000));
        tick(1);
        expect_obs("t5_after_4", M_CLK, mk(3'b000, 0, 0, 0, 4'd1, 4'b0000));

        // target selection (floor 1, down)
        cab_btn = 4'b0001;
        tick(1);
        cab_btn = 4'b0000;
        ack_offer();
        expect_obs("sel_dn", M_NS | M_PEND, mk(3'b100, 0, 0, 0, 4'd0, 4'b0101));
        UD_Answer = 1'b1;
        ack_offer();
        expect_obs("sel_up", M_NS, mk(3'b110, 0, 0, 0, 4'd0, 4'b0000));
        Actual_Stage = 2'd2; Delay = 1'b1;
        tick(1);
        Delay = 1'b0;
        tick(1);
        ack_offer();
        expect_obs("sel_excl_cur", M_NS | M_OC, mk(3'b100, 1, 0, 0, 4'd0, 4'b0000));
        STOP = 1'b1;
        tick(1);
        expect_obs("ud_below", M_UD | M_NOS | M_OC, mk(3'b000, 0, 0, 1, 4'd0, 4'b0000));
        STOP = 1'b0;
        tick(1);

        // held button survives its own service
        cab_btn = 4'b0100; reset_clock = 1'b1;
        tick(1);
        cab_btn = 4'b0000; reset_clock = 1'b0;
        expect_obs("t6_held", M_PEND | M_OC, mk(3'b000, 1, 0, 0, 4'd0, 4'b0101));
        tick(1);
        reset_clock = 1'b1;
        tick(1);
        reset_clock = 1'b0;
        expect_obs("t6_released", M_PEND | M_OC, mk(3'b000, 0, 0, 0, 4'd0, 4'b0001));

        // reset mid-operation
        hall_up = 4'b0100;
        tick(1);
        hall_up = 4'b0000;
        tick(2);
        reset = 1'b0;
        #1;
        expect_obs("t1_async_reset", M_ALL, mk(3'b000, 0, 1, 0, 4'd0, 4'b0000));
        tick(1);
        reset = 1'b1; Actual_Stage = 2'd0; UD_Answer = 1'b1;
        tick(1);
        expect_obs("t1_after_reset", M_PEND | M_NS | M_UD, mk(3'b000, 0, 1, 0, 4'd0, 4'b0000));

        // selection with hall up at 1 and cab at 3 from floor 0
`ifdef CAB_PRIORITY_EN
        prio_exp = 3'b111;
`else
        prio_exp = 3'b101;
`endif
        hall_up = 4'b0010; cab_btn = 4'b1000;
        tick(1);
        hall_up = 4'b0000; cab_btn = 4'b0000;
        tick(1);
        expect_obs("t6_prio", M_NS | M_PEND, mk(prio_exp, 0, 0, 0, 4'd0, 4'b1010));

        waitc = 0;
        while (exp_q.size() > 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
